// File: rtl/decode_operand_stage.sv
// decode_operand_stage
//   Decode/operand stage of the RISC-V integer pipeline, between the IF/ID
//   latch and EX.
//   - Drives the register-file read addresses straight from the IF/ID
//     instruction. The regfile registers its read data on posedge, so that
//     data lines up with the ID/EX register held here.
//   - Decodes the instruction, builds the sign-extended immediate and holds
//     the ID/EX pipeline register.
//   - Forwards EX/MEM and MEM/WB results onto the rs1/rs2 operands.
//   - Detects load-use hazards: stalls IF for one cycle and injects a bubble.
//
// Ports
//   clock, clear            rising-edge clock, async active-high reset
//   if_valid/instr/pc       IF/ID latch contents
//   flush                   EX redirect; ID/EX loads a bubble
//   stall                   hold PC and IF/ID this cycle
//   rf_addrA/B, rf_dataA/B  regfile read port (data one cycle after address)
//   exmem_*, memwb_*        forwarding sources
//   ex_*                    ID/EX register contents; ex_opA/B forwarded operands
module decode_operand_stage #(
    parameter int width     = 32,
    parameter int addrWidth = 5
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 if_valid,
    input  logic [width-1:0]     if_instr,
    input  logic [width-1:0]     if_pc,
    input  logic                 flush,
    output logic                 stall,
    output logic [addrWidth-1:0] rf_addrA,
    output logic [addrWidth-1:0] rf_addrB,
    input  logic [width-1:0]     rf_dataA,
    input  logic [width-1:0]     rf_dataB,
    input  logic                 exmem_regwrite,
    input  logic [addrWidth-1:0] exmem_rd,
    input  logic [width-1:0]     exmem_result,
    input  logic                 memwb_regwrite,
    input  logic [addrWidth-1:0] memwb_rd,
    input  logic [width-1:0]     memwb_result,
    output logic                 ex_valid,
    output logic                 ex_regwrite,
    output logic                 ex_memread,
    output logic                 ex_memwrite,
    output logic                 ex_illegal,
    output logic [width-1:0]     ex_pc,
    output logic [6:0]           ex_opcode,
    output logic [2:0]           ex_funct3,
    output logic                 ex_funct7b5,
    output logic [addrWidth-1:0] ex_rd,
    output logic [addrWidth-1:0] ex_rs1,
    output logic [addrWidth-1:0] ex_rs2,
    output logic [width-1:0]     ex_imm,
    output logic [width-1:0]     ex_opA,
    output logic [width-1:0]     ex_opB
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef struct packed {
        logic                 valid;
        logic                 regwrite;
        logic                 memread;
        logic                 memwrite;
        logic                 illegal;
        logic [width-1:0]     pc;
        logic [6:0]           opcode;
        logic [2:0]           funct3;
        logic                 funct7b5;
        logic [addrWidth-1:0] rd;
        logic [addrWidth-1:0] rs1;
        logic [addrWidth-1:0] rs2;
        logic [width-1:0]     imm;
    } idex_t;

    idex_t idex_q;
    idex_t idex_d;

    // Instruction fields
    logic [6:0]           opcode;
    logic [addrWidth-1:0] rd, rs1, rs2;

    assign opcode = if_instr[6:0];
    assign rd     = if_instr[11:7];
    assign rs1    = if_instr[19:15];
    assign rs2    = if_instr[24:20];

    // IF holds if_instr while stalled, so the regfile simply re-reads.
    assign rf_addrA = rs1;
    assign rf_addrB = rs2;

    // Immediate formats (32-bit view, sign-extended to width below)
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign imm_i = {{20{if_instr[31]}}, if_instr[31:20]};
    assign imm_s = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
    assign imm_b = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                    if_instr[30:25], if_instr[11:8], 1'b0};
    assign imm_u = {if_instr[31:12], 12'b0};
    assign imm_j = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                    if_instr[20], if_instr[30:21], 1'b0};

    logic        is_legal, wr_op, dec_memread, dec_memwrite;
    logic        uses_rs1, uses_rs2;
    logic [31:0] imm32;

    always_comb begin
        is_legal     = 1'b1;
        wr_op        = 1'b0;
        dec_memread  = 1'b0;
        dec_memwrite = 1'b0;
        uses_rs1     = 1'b1;
        uses_rs2     = 1'b0;
        imm32        = '0;
        case (opcode)
            OP_LOAD:   begin wr_op = 1'b1; dec_memread = 1'b1; imm32 = imm_i; end
            OP_STORE:  begin dec_memwrite = 1'b1; uses_rs2 = 1'b1; imm32 = imm_s; end
            OP_BRANCH: begin uses_rs2 = 1'b1; imm32 = imm_b; end
            OP_OPIMM:  begin wr_op = 1'b1; imm32 = imm_i; end
            OP_OP:     begin wr_op = 1'b1; uses_rs2 = 1'b1; end
            OP_LUI,
            OP_AUIPC:  begin wr_op = 1'b1; uses_rs1 = 1'b0; imm32 = imm_u; end
            OP_JAL:    begin wr_op = 1'b1; uses_rs1 = 1'b0; imm32 = imm_j; end
            OP_JALR:   begin wr_op = 1'b1; imm32 = imm_i; end
            default:   begin is_legal = 1'b0; uses_rs1 = 1'b0; end
        endcase
    end

    // Load-use hazard against the instruction currently in ID/EX
    logic hazard;

    assign hazard = if_valid & idex_q.valid & idex_q.memread & (idex_q.rd != '0) &
                    ((uses_rs1 & (rs1 == idex_q.rd)) | (uses_rs2 & (rs2 == idex_q.rd)));

    // Flush wins over a hazard: the instruction in IF/ID is being discarded.
    assign stall = hazard & ~flush;

    always_comb begin
        idex_d          = '0;
        idex_d.valid    = 1'b1;
        idex_d.regwrite = wr_op & (rd != '0);
        idex_d.memread  = dec_memread;
        idex_d.memwrite = dec_memwrite;
        idex_d.illegal  = ~is_legal;
        idex_d.pc       = if_pc;
        idex_d.opcode   = opcode;
        idex_d.funct3   = if_instr[14:12];
        idex_d.funct7b5 = if_instr[30];
        idex_d.rd       = rd;
        idex_d.rs1      = rs1;
        idex_d.rs2      = rs2;
        idex_d.imm      = width'($signed(imm32));
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear)
            idex_q <= '0;
        else if (flush | hazard | ~if_valid)
            idex_q <= '0;
        else
            idex_q <= idex_d;
    end

    assign ex_valid    = idex_q.valid;
    assign ex_regwrite = idex_q.regwrite;
    assign ex_memread  = idex_q.memread;
    assign ex_memwrite = idex_q.memwrite;
    assign ex_illegal  = idex_q.illegal;
    assign ex_pc       = idex_q.pc;
    assign ex_opcode   = idex_q.opcode;
    assign ex_funct3   = idex_q.funct3;
    assign ex_funct7b5 = idex_q.funct7b5;
    assign ex_rd       = idex_q.rd;
    assign ex_rs1      = idex_q.rs1;
    assign ex_rs2      = idex_q.rs2;
    assign ex_imm      = idex_q.imm;

    // Operand forwarding. EX/MEM is the younger write and takes priority;
    // anything older than MEM/WB is already in the regfile (negedge write).
    function automatic logic [width-1:0] fwd(
        input logic [addrWidth-1:0] rs,
        input logic [width-1:0]     rf,
        input logic                 exw,
        input logic [addrWidth-1:0] exrd,
        input logic [width-1:0]     exres,
        input logic                 wbw,
        input logic [addrWidth-1:0] wbrd,
        input logic [width-1:0]     wbres
    );
        if (rs == '0)                  return '0;
        else if (exw && (exrd == rs))  return exres;
        else if (wbw && (wbrd == rs))  return wbres;
        else                           return rf;
    endfunction

    assign ex_opA = fwd(idex_q.rs1, rf_dataA, exmem_regwrite, exmem_rd, exmem_result,
                        memwb_regwrite, memwb_rd, memwb_result);
    assign ex_opB = fwd(idex_q.rs2, rf_dataB, exmem_regwrite, exmem_rd, exmem_result,
                        memwb_regwrite, memwb_rd, memwb_result);

endmodule

// File: tb/tb_decode_operand_stage.sv
module tb_decode_operand_stage;

    logic        clock = 1'b0;
    logic        clear;
    logic        if_valid;
    logic [31:0] if_instr, if_pc;
    logic        flush;
    logic        stall;
    logic [4:0]  rf_addrA, rf_addrB;
    logic [31:0] rf_dataA, rf_dataB;
    logic        exmem_regwrite, memwb_regwrite;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_illegal;
    logic [31:0] ex_pc, ex_imm, ex_opA, ex_opB;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic        ex_funct7b5;
    logic [4:0]  ex_rd, ex_rs1, ex_rs2;

    decode_operand_stage #(.width(32), .addrWidth(5)) dut (
        .clock(clock), .clear(clear),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .flush(flush), .stall(stall),
        .rf_addrA(rf_addrA), .rf_addrB(rf_addrB),
        .rf_dataA(rf_dataA), .rf_dataB(rf_dataB),
        .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_illegal(ex_illegal),
        .ex_pc(ex_pc), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
        .ex_funct7b5(ex_funct7b5), .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_imm(ex_imm), .ex_opA(ex_opA), .ex_opB(ex_opB)
    );

    always #5 clock = ~clock;

    int vecs = 0;
    int errs = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h, want %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit          valid, regwrite, memread, memwrite, illegal;
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [2:0]  f3;
        bit          f7b5;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
    } idex_m_t;

    idex_m_t m;

    function automatic idex_m_t bubble();
        idex_m_t b;
        b.valid = 0; b.regwrite = 0; b.memread = 0; b.memwrite = 0; b.illegal = 0;
        b.pc = 0; b.opcode = 0; b.f3 = 0; b.f7b5 = 0;
        b.rd = 0; b.rs1 = 0; b.rs2 = 0; b.imm = 0;
        return b;
    endfunction

    function automatic bit is_legal(input logic [31:0] ins);
        int op = int'(ins[6:0]);
        return op inside {'h03, 'h23, 'h63, 'h13, 'h33, 'h37, 'h17, 'h6f, 'h67};
    endfunction

    function automatic bit m_uses1(input logic [31:0] ins);
        int op = int'(ins[6:0]);
        return is_legal(ins) && !(op inside {'h37, 'h17, 'h6f});
    endfunction

    function automatic bit m_uses2(input logic [31:0] ins);
        int op = int'(ins[6:0]);
        return op inside {'h33, 'h23, 'h63};
    endfunction

    // Immediate value computed arithmetically from the field weights
    function automatic logic [31:0] m_imm(input logic [31:0] ins);
        int op = int'(ins[6:0]);
        int s  = int'($signed(ins));
        int sg = s >>> 31;
        if (op inside {'h13, 'h03, 'h67}) return s >>> 20;
        if (op == 'h23) return (s >>> 25) * 32 + int'(ins[11:7]);
        if (op == 'h63) return sg * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
                              + int'(ins[11:8]) * 2;
        if (op inside {'h37, 'h17}) return (s >>> 12) * 4096;
        if (op == 'h6f) return sg * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
                              + int'(ins[30:21]) * 2;
        return 0;
    endfunction

    function automatic idex_m_t m_decode(input logic [31:0] ins, input logic [31:0] pc);
        idex_m_t d;
        int op = int'(ins[6:0]);
        d.valid    = 1;
        d.illegal  = !is_legal(ins);
        d.regwrite = (op inside {'h33, 'h13, 'h03, 'h37, 'h17, 'h6f, 'h67}) && (ins[11:7] != 0);
        d.memread  = (op == 'h03);
        d.memwrite = (op == 'h23);
        d.pc = pc; d.opcode = ins[6:0]; d.f3 = ins[14:12]; d.f7b5 = ins[30];
        d.rd = ins[11:7]; d.rs1 = ins[19:15]; d.rs2 = ins[24:20];
        d.imm = m_imm(ins);
        return d;
    endfunction

    function automatic bit m_hazard();
        logic [4:0] r1 = if_instr[19:15];
        logic [4:0] r2 = if_instr[24:20];
        return if_valid && m.valid && m.memread && m.rd != 0 &&
               ((m_uses1(if_instr) && r1 == m.rd) || (m_uses2(if_instr) && r2 == m.rd));
    endfunction

    function automatic logic [31:0] m_fwd(input logic [4:0] rs, input logic [31:0] rf);
        if (rs == 0) return 0;
        if (exmem_regwrite && exmem_rd == rs) return exmem_result;
        if (memwb_regwrite && memwb_rd == rs) return memwb_result;
        return rf;
    endfunction

    // Compare every output against the model, #1 after inputs settle
    task automatic check_all();
        #1;
        chk("stall",    32'(stall),       32'(m_hazard() && !flush));
        chk("rf_addrA", 32'(rf_addrA),    32'(if_instr[19:15]));
        chk("rf_addrB", 32'(rf_addrB),    32'(if_instr[24:20]));
        chk("valid",    32'(ex_valid),    32'(m.valid));
        chk("regwrite", 32'(ex_regwrite), 32'(m.regwrite));
        chk("memread",  32'(ex_memread),  32'(m.memread));
        chk("memwrite", 32'(ex_memwrite), 32'(m.memwrite));
        chk("illegal",  32'(ex_illegal),  32'(m.illegal));
        chk("pc",       ex_pc,            m.pc);
        chk("opcode",   32'(ex_opcode),   32'(m.opcode));
        chk("funct3",   32'(ex_funct3),   32'(m.f3));
        chk("funct7b5", 32'(ex_funct7b5), 32'(m.f7b5));
        chk("rd",       32'(ex_rd),       32'(m.rd));
        chk("rs1",      32'(ex_rs1),      32'(m.rs1));
        chk("rs2",      32'(ex_rs2),      32'(m.rs2));
        chk("imm",      ex_imm,           m.imm);
        chk("opA",      ex_opA,           m_fwd(m.rs1, rf_dataA));
        chk("opB",      ex_opB,           m_fwd(m.rs2, rf_dataB));
    endtask

    // Advance one clock: model follows the pre-edge inputs
    task automatic tick();
        idex_m_t nxt;
        if (flush || m_hazard() || !if_valid) nxt = bubble();
        else nxt = m_decode(if_instr, if_pc);
        @(posedge clock);
        m = nxt;
        @(negedge clock);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        m = bubble();
        check_all();
        chk("clr_stall", 32'(stall), 32'd0);
        chk("clr_opA",   ex_opA,     32'd0);
        clear = 1'b0;
    endtask

    task automatic idle();
        if_valid = 0; flush = 0; exmem_regwrite = 0; memwb_regwrite = 0;
        exmem_rd = 0; memwb_rd = 0; exmem_result = 0; memwb_result = 0;
        rf_dataA = 0; rf_dataB = 0;
    endtask

    task automatic issue(input logic [31:0] ins);
        if_valid = 1; if_instr = ins; if_pc = if_pc + 4;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        logic [6:0]  ops [10] = '{7'h03, 7'h23, 7'h63, 7'h13, 7'h33,
                                  7'h37, 7'h17, 7'h6f, 7'h67, 7'h7f};
        ins = $urandom;
        ins[6:0]   = ops[$urandom_range(0, 9)];
        if ($urandom_range(0, 9) == 0) ins[6:0] = 7'($urandom);
        ins[11:7]  = 5'($urandom_range(0, 3));
        ins[19:15] = 5'($urandom_range(0, 3));
        ins[24:20] = 5'($urandom_range(0, 3));
        return ins;
    endfunction

    localparam logic [31:0] LW_X5  = 32'h00012283; // lw  x5,0(x2)
    localparam logic [31:0] ADD_X6 = 32'h00128333; // add x6,x5,x1
    localparam logic [31:0] LW_X0  = 32'h00012003; // lw  x0,0(x2)
    localparam logic [31:0] ADD_X0 = 32'h00100333; // add x6,x0,x1

    initial begin
        idle();
        if_instr = 0; if_pc = 32'h1000;
        clear = 1'b1;
        m = bubble();
        #2;
        check_all();
        @(negedge clock);
        clear = 1'b0;

        // addi x1,x0,5
        issue(32'h00500093);
        check_all(); tick();
        if_valid = 0;
        check_all();
        chk("addi_valid", 32'(ex_valid),    32'd1);
        chk("addi_rw",    32'(ex_regwrite), 32'd1);
        chk("addi_rd",    32'(ex_rd),       32'd1);
        chk("addi_imm",   ex_imm,           32'd5);
        chk("addi_opA",   ex_opA,           32'd0);
        tick();

        // Forwarding priority on add x4,x3,x3
        issue(32'h00318233);
        check_all(); tick();
        if_valid = 0; rf_dataA = 32'h11; rf_dataB = 32'h11;
        exmem_regwrite = 1; exmem_rd = 3; exmem_result = 32'hAA;
        memwb_regwrite = 1; memwb_rd = 3; memwb_result = 32'hBB;
        check_all();
        chk("fwd_ex_A", ex_opA, 32'hAA);
        chk("fwd_ex_B", ex_opB, 32'hAA);
        exmem_regwrite = 0;
        check_all();
        chk("fwd_wb_A", ex_opA, 32'hBB);
        chk("fwd_wb_B", ex_opB, 32'hBB);
        memwb_regwrite = 0;
        check_all();
        chk("fwd_rf_A", ex_opA, 32'h11);
        tick(); idle();

        // Load-use: one-cycle stall, bubble, then MEM/WB forward
        issue(LW_X5); check_all(); tick();
        issue(ADD_X6); check_all();
        chk("lu_stall", 32'(stall), 32'd1);
        tick();
        check_all();
        chk("lu_stall_end", 32'(stall),    32'd0);
        chk("lu_bubble",    32'(ex_valid), 32'd0);
        tick();
        if_valid = 0; memwb_regwrite = 1; memwb_rd = 5; memwb_result = 32'h1234;
        check_all();
        chk("lu_rs1", 32'(ex_rs1), 32'd5);
        chk("lu_fwd", ex_opA,      32'h1234);
        tick(); idle();

        // Load-use with flush: no stall, bubble
        issue(LW_X5); check_all(); tick();
        issue(ADD_X6); flush = 1;
        check_all();
        chk("fl_stall", 32'(stall), 32'd0);
        tick(); flush = 0; if_valid = 0;
        check_all();
        chk("fl_bubble", 32'(ex_valid), 32'd0);
        // x0 destination never stalls
        issue(LW_X0); check_all(); tick();
        issue(ADD_X0); check_all();
        chk("x0_stall", 32'(stall), 32'd0);
        tick(); idle();

        // Store immediate and illegal opcode
        issue(32'hFE20AE23); check_all(); tick();
        issue(32'h0000007F); check_all();
        chk("sw_imm", ex_imm,           32'hFFFFFFFC);
        chk("sw_mw",  32'(ex_memwrite), 32'd1);
        chk("sw_rw",  32'(ex_regwrite), 32'd0);
        tick(); if_valid = 0;
        check_all();
        chk("ill",    32'(ex_illegal),  32'd1);
        chk("ill_rw", 32'(ex_regwrite), 32'd0);
        chk("ill_mr", 32'(ex_memread),  32'd0);
        chk("ill_mw", 32'(ex_memwrite), 32'd0);
        tick();

        // Reset mid-stall, then normal load on the next edge
        issue(LW_X5); check_all(); tick();
        issue(ADD_X6); check_all();
        chk("rst_pre_stall", 32'(stall), 32'd1);
        pulse_clear();
        check_all();
        tick();
        check_all();
        chk("rst_reload", 32'(ex_valid), 32'd1);
        tick(); idle();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if (!(m_hazard() && !flush)) begin
                if_instr = rand_instr();
                if_pc    = $urandom;
            end
            if_valid       = ($urandom_range(0, 7) != 0);
            flush          = ($urandom_range(0, 7) == 0);
            rf_dataA       = $urandom;
            rf_dataB       = $urandom;
            exmem_regwrite = 1'($urandom);
            exmem_rd       = 5'($urandom_range(0, 3));
            exmem_result   = $urandom;
            memwb_regwrite = 1'($urandom);
            memwb_rd       = 5'($urandom_range(0, 3));
            memwb_result   = $urandom;
            check_all();
            if ($urandom_range(0, 49) == 0) pulse_clear();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
